// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, synchronizer reset levels and shift helper for the SPI slave receiver
package spi_pkg;
    localparam int SPI_BYTE_W              = 8;
    localparam int SPI_BIT_CNT_W           = 3;
    localparam int SPI_SYNC_STAGES_DEFAULT = 2;
    localparam logic SPI_CS_SYNC_RST       = 1'b1;
    localparam logic SPI_SCLK_SYNC_RST     = 1'b0;
    localparam logic SPI_MOSI_SYNC_RST     = 1'b0;

    function automatic logic [SPI_BYTE_W-1:0] spi_shift_in(
        input logic [SPI_BYTE_W-1:0] s,
        input logic                  b
    );
        return {s[SPI_BYTE_W-2:0], b};
    endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop input synchronizer with level and single-cycle rise/fall strobes
module spi_sync
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_hist;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_chain <= {SYNC_STAGES{RST_VAL}};
            r_hist  <= RST_VAL;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
            r_hist  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign o_level = r_chain[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_hist;
    assign o_fall  = ~o_level & r_hist;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode 0 slave, MSB first; synchronizes the pins, assembles bytes and shifts readback on MISO
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  spi_sclk_in,
    input  logic                  spi_cs_n_in,
    input  logic                  spi_mosi_in,
    output logic                  spi_miso_out,
    input  logic [SPI_BYTE_W-1:0] tx_data_in,
    output logic [SPI_BYTE_W-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  transaction_valid_out,
    output logic                  frame_error_out
);
    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_cs_n, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
    logic w_act, w_cs_start, w_cs_end, w_rx_edge, w_tx_edge;

    logic [SPI_BIT_CNT_W-1:0] r_bit_cnt;
    logic [SPI_BYTE_W-1:0]    r_rx_shift, r_tx_shift, r_data;
    logic [SYNC_STAGES-1:0]   r_warm;
    logic r_armed, r_done, r_valid, r_err, r_tv, r_miso;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SPI_SCLK_SYNC_RST)) u_sclk (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .i_async(spi_sclk_in),
        .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SPI_CS_SYNC_RST)) u_cs (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .i_async(spi_cs_n_in),
        .o_level(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(SPI_MOSI_SYNC_RST)) u_mosi (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .i_async(spi_mosi_in),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    // The CS chain resets to inactive, so a transaction already running at reset release
    // only shows up as a fake fall; arming waits for a real high level once the chain holds pin samples.
    assign w_act      = ~w_cs_n & r_armed;
    assign w_cs_start = w_cs_fall & r_armed;
    assign w_cs_end   = w_cs_rise;
    assign w_rx_edge  = w_sclk_rise & w_act;
    assign w_tx_edge  = w_sclk_fall & w_act;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_warm     <= '0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_tv       <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_warm  <= {r_warm[SYNC_STAGES-2:0], 1'b1};
            r_armed <= r_armed | (r_warm[SYNC_STAGES-1] & w_cs_n);
            r_done  <= w_rx_edge & (&r_bit_cnt);
            r_valid <= r_done;
            r_err   <= w_cs_end & (|r_bit_cnt);
            r_tv    <= w_act;
            r_miso  <= w_act & r_tx_shift[SPI_BYTE_W-1];
            if (r_done)
                r_data <= r_rx_shift;
            if (w_cs_end) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
            end else if (w_rx_edge) begin
                r_bit_cnt  <= r_bit_cnt + SPI_BIT_CNT_W'(1);
                r_rx_shift <= spi_shift_in(r_rx_shift, w_mosi);
            end
            if (w_cs_start)
                r_tx_shift <= tx_data_in;
            else if (w_tx_edge)
                r_tx_shift <= (r_bit_cnt == '0) ? tx_data_in : spi_shift_in(r_tx_shift, 1'b0);
        end
    end

    assign data_out              = r_data;
    assign data_valid_out        = r_valid;
    assign frame_error_out       = r_err;
    assign transaction_valid_out = r_tv;
    assign spi_miso_out          = r_miso;
endmodule
